// File: rtl/magcmp_pkg.sv
// Shared types and golden comparison function for the magnitude-comparator sweep checker.
package magcmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Widest operand the golden function accepts; narrower operands are zero-extended.
  localparam int CMP_MAX_W = 16;

  function automatic logic [2:0] cmp_expect(input logic [CMP_MAX_W-1:0] a,
                                            input logic [CMP_MAX_W-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/magcmp_ref.sv
// Golden combinational magnitude comparator; returns {gt, eq, lt} for unsigned operands.
module magcmp_ref
  import magcmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [2:0]       o_expect
);

  assign o_expect = cmp_expect(CMP_MAX_W'(i_a), CMP_MAX_W'(i_b));

endmodule

// File: rtl/magcmp_sweep_checker.sv
// Exhaustive (A,B) sweep driver and response checker for an external magnitude comparator.
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse, busy covers WAIT/CHECK.
module magcmp_sweep_checker
  import magcmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output state_t           dbg_state
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SET_W-1:0] r_settle;
  logic [ERR_W-1:0] r_err;
  logic             r_pass;
  logic             r_ffv;
  logic [WIDTH-1:0] r_ffa;
  logic [WIDTH-1:0] r_ffb;

  logic [2:0]       w_expect;
  logic             w_mismatch;
  logic             w_last;
  logic             w_settled;
  logic [ERR_W-1:0] w_err_next;

  magcmp_ref #(.WIDTH(WIDTH)) u_ref (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_expect (w_expect)
  );

  // Exact 3-bit compare, so any non-one-hot response counts as a failure.
  assign w_mismatch = ({cmp_gt, cmp_eq, cmp_lt} != w_expect);
  assign w_last     = (&r_a) && (&r_b);
  assign w_settled  = (r_settle == SET_W'(SETTLE - 1));
  assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + ERR_W'(1) : r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WAIT;
      S_WAIT:  if (w_settled) w_next = S_CHECK;
      S_CHECK: w_next = w_last ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
      r_ffv    <= 1'b0;
      r_ffa    <= '0;
      r_ffb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= '0;
            r_b      <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
            r_ffv    <= 1'b0;
            r_ffa    <= '0;
            r_ffb    <= '0;
          end
        end
        S_WAIT: r_settle <= w_settled ? '0 : r_settle + SET_W'(1);
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ffv) begin
            r_ffv <= 1'b1;
            r_ffa <= r_a;
            r_ffb <= r_b;
          end
          // B is the low half of the pair counter, so its wrap carries into A.
          if (w_last) r_pass <= (w_err_next == '0);
          else        {r_a, r_b} <= {r_a, r_b} + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  assign a_out            = r_a;
  assign b_out            = r_b;
  assign busy             = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done             = (r_state == S_DONE);
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_a     = r_ffa;
  assign first_fail_b     = r_ffb;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_magcmp_sweep_checker.sv
// Bench for magcmp_sweep_checker: table of comparator fault modes plus reset and back-to-back sequences.
module tb_magcmp_sweep_checker;
  import magcmp_pkg::*;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  int           mode = 0;

  logic [W-1:0] a_out, b_out, ffa, ffb;
  logic         gt, eq, lt, busy, done, pass, ffv;
  logic [7:0]   err_count;
  state_t       dbg_state;

  logic [W-1:0] a2, b2, ffa2, ffb2;
  logic         busy2, done2, pass2, ffv2;
  logic [1:0]   err2;
  state_t       dbg_state2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Comparator model with selectable faults: 0 good, 1 gt/lt swapped, 2 eq stuck 0, 3 gt stuck 1.
  always_comb begin
    gt = a_out > b_out;
    eq = a_out == b_out;
    lt = a_out < b_out;
    case (mode)
      1: begin gt = a_out < b_out; lt = a_out > b_out; end
      2: eq = 1'b0;
      3: gt = 1'b1;
      default: ;
    endcase
  end

  magcmp_sweep_checker #(.WIDTH(W), .SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out),
    .cmp_gt(gt), .cmp_eq(eq), .cmp_lt(lt),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_a(ffa), .first_fail_b(ffb),
    .dbg_state(dbg_state)
  );

  // Second checker with a 2-bit error counter and its flags tied to 000.
  magcmp_sweep_checker #(.WIDTH(W), .SETTLE(1), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a2), .b_out(b2),
    .cmp_gt(1'b0), .cmp_eq(1'b0), .cmp_lt(1'b0),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_a(ffa2), .first_fail_b(ffb2),
    .dbg_state(dbg_state2)
  );

  typedef struct {
    int         mode;
    logic [7:0] exp_err;
    logic       exp_pass;
    logic       exp_ffv;
    logic [1:0] exp_ffa;
    logic [1:0] exp_ffb;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepts a start from IDLE, then counts edges until done; returns edges after the accept edge.
  task automatic run_sweep(output int lat);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("state_after_accept", 32'(dbg_state), 32'(S_WAIT));
    chk("a_after_accept", a_out, 0);
    lat = 0;
    while (!done && lat < 200) begin
      start = (lat == 10);
      step();
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int done_edges[$];

    vecs[0] = '{mode: 0, exp_err: 8'd0,  exp_pass: 1'b1, exp_ffv: 1'b0, exp_ffa: 2'd0, exp_ffb: 2'd0};
    vecs[1] = '{mode: 1, exp_err: 8'd12, exp_pass: 1'b0, exp_ffv: 1'b1, exp_ffa: 2'd0, exp_ffb: 2'd1};
    vecs[2] = '{mode: 2, exp_err: 8'd4,  exp_pass: 1'b0, exp_ffv: 1'b1, exp_ffa: 2'd0, exp_ffb: 2'd0};
    vecs[3] = '{mode: 3, exp_err: 8'd10, exp_pass: 1'b0, exp_ffv: 1'b1, exp_ffa: 2'd0, exp_ffb: 2'd0};

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    chk("idle_no_start", 32'(dbg_state), 32'(S_IDLE));

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      run_sweep(lat);
      chk($sformatf("v%0d_latency", i), lat, 32);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      chk($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("v%0d_ffv", i), ffv, vecs[i].exp_ffv);
      chk($sformatf("v%0d_ffa", i), ffa, vecs[i].exp_ffa);
      chk($sformatf("v%0d_ffb", i), ffb, vecs[i].exp_ffb);
      chk($sformatf("v%0d_sat_done", i), done2, 1);
      chk($sformatf("v%0d_sat_err", i), err2, 3);
      chk($sformatf("v%0d_sat_pass", i), pass2, 0);
      chk($sformatf("v%0d_sat_ffv", i), ffv2, 1);
      step();
      chk($sformatf("v%0d_idle_after", i), 32'(dbg_state), 32'(S_IDLE));
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_a_hold", i), a_out, 3);
      chk($sformatf("v%0d_b_hold", i), b_out, 3);
      chk($sformatf("v%0d_pass_hold", i), pass, vecs[i].exp_pass);
    end

    // Reset in the middle of a failing sweep.
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_a", a_out, 0);
    chk("midrst_b", b_out, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_ffv", ffv, 0);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    mode = 0;
    run_sweep(lat);
    chk("post_rst_latency", lat, 32);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);
    step();

    // start held high: back-to-back sweeps with a single IDLE cycle between them.
    start = 1'b1;
    step();
    for (int i = 1; i < 100; i++) begin
      step();
      if (done) done_edges.push_back(i);
    end
    start = 1'b0;
    chk("held_done_count", done_edges.size(), 2);
    if (done_edges.size() == 2) begin
      chk("held_done_first", done_edges[0], 32);
      chk("held_done_second", done_edges[1], 66);
    end
    lat = 0;
    while (!done && lat < 200) begin
      step();
      lat++;
    end
    chk("held_third_done_seen", done, 1);
    chk("held_third_pass", pass, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
